// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, sync-flag payload and window helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam int unsigned RGB_W  = 12;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned FLAG_W = 3;

  // Per-pixel timing flags carried alongside the renderer latency.
  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } sync_flags_t;

  // Delay-line fill value: blanked, both syncs idle.
  localparam sync_flags_t FLAGS_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  // True when lo <= v < hi (unsigned).
  function automatic logic in_window(logic [CNT_W-1:0] v, int unsigned lo, int unsigned hi);
    return (v >= CNT_W'(lo)) && (v < CNT_W'(hi));
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit shift register of DEPTH stages advanced only when en=1.
// Ports: clk, rst (async high), en (shift enable), din (stage-0 input),
//        dout (value shifted in DEPTH enabled cycles earlier; din itself when DEPTH=0).
module vga_delay_line #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    // Zero depth: straight wire; clock/reset/enable are intentionally unused.
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst, en};
    assign dout = din;
  end else begin : g_shift
    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];

    // Next-state: hold unless enabled, then shift one stage.
    always_comb begin
      sr_d = sr_q;
      if (en) begin
        sr_d[0] = din;
        for (int i = 1; i < int'(DEPTH); i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          sr_q[i] <= INIT;
        end
      end else begin
        sr_q <= sr_d;
      end
    end

    assign dout = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_out.sv
// vga_timing_out: raster counters, sync decode and VGA pin register.
// Ports: clk, rst (async high), pix_ce (pixel tick), rgb_in (renderer colour,
//        PIPE_DLY ticks behind px_x/px_y), px_x/px_y/px_active (registered raster
//        position), frame_start (pix_ce at (0,0), combinational), vgaRed/vgaGreen/
//        vgaBlue, Hsync, Vsync (registered pins, active-low syncs).
module vga_timing_out #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [11:0] rgb_in,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_active,
  output logic        frame_start,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue,
  output logic        Hsync,
  output logic        Vsync
);

  import vga_pkg::*;

  localparam int unsigned LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_LO     = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI     = HS_LO + H_SYNC;
  localparam int unsigned VS_LO     = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI     = VS_LO + V_SYNC;

  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic              act_q, act_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  sync_flags_t       raw_flags, dly_flags;
  logic [FLAG_W-1:0] raw_bits, dly_bits;

  // Raster counters; px_active is registered alongside the position it describes.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    act_d = act_q;
    if (pix_ce) begin
      if (x_q == CNT_W'(LINE_LEN - 1)) begin
        x_d = '0;
        y_d = (y_q == CNT_W'(FRAME_LEN - 1)) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
      act_d = (x_d < CNT_W'(H_ACTIVE)) && (y_d < CNT_W'(V_ACTIVE));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      act_q <= 1'b1;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      act_q <= act_d;
    end
  end

  // Undelayed flags for the current raster position.
  always_comb begin
    raw_flags.active = act_q;
    raw_flags.hs_n   = !in_window(x_q, HS_LO, HS_HI);
    raw_flags.vs_n   = !in_window(y_q, VS_LO, VS_HI);
  end

  assign raw_bits  = raw_flags;
  assign dly_flags = sync_flags_t'(dly_bits);

  // Flags ride alongside the renderer so they meet rgb_in for the same pixel.
  vga_delay_line #(
    .W     (FLAG_W),
    .DEPTH (PIPE_DLY),
    .INIT  (FLAGS_IDLE)
  ) u_flag_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_ce),
    .din  (raw_bits),
    .dout (dly_bits)
  );

  // Pin register: colour gated by delayed active, syncs from the delay line.
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (pix_ce) begin
      rgb_d = dly_flags.active ? rgb_in : '0;
      hs_d  = dly_flags.hs_n;
      vs_d  = dly_flags.vs_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign px_x        = x_q;
  assign px_y        = y_q;
  assign px_active   = act_q;
  assign frame_start = pix_ce && (x_q == '0) && (y_q == '0);
  assign vgaRed      = rgb_q[11:8];
  assign vgaGreen    = rgb_q[7:4];
  assign vgaBlue     = rgb_q[3:0];
  assign Hsync       = hs_q;
  assign Vsync       = vs_q;

endmodule
